// File: rtl/seg7_scan_capture_if.sv
// Bus between a 4-digit multiplexed seven-segment driver and its capture block.
// The driver side (master) owns the active-low segment/anode lines; the capture
// side (slave) reports decoded frames and sampling errors back.
interface seg7_scan_capture_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] frame_digits;
  logic [3:0]  frame_blank;
  logic        frame_valid;
  logic        bad_code;
  logic        bad_an;

  modport master (
    output seg, an,
    input  frame_digits, frame_blank, frame_valid, bad_code, bad_an
  );

  modport slave (
    input  seg, an,
    output frame_digits, frame_blank, frame_valid, bad_code, bad_an
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Receive end of a multiplexed seven-segment bus. Synchronizes seg/an, waits for
// them to settle, decodes each glyph back to a hex nibble and publishes a frame
// once all four digits have been captured.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | gathering digits; frame regs load when all four are seen
// PUBLISH | one cycle: frame_valid high, seen mask cleared
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_capture_if.slave   bus
);

  localparam logic [7:0] STABLE_LD = 8'(STABLE_CYCLES);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t          state, state_nxt;
  logic [10:0]     s1, s2;
  logic [7:0]      cnt_rem;
  logic            sample;
  logic [3:0]      smp_an, an_low;
  logic [6:0]      smp_seg;
  logic            an_idle, an_one;
  logic            glyph_ok, glyph_blank;
  logic [3:0]      glyph_nib;
  logic [3:0][3:0] cap_digit;
  logic [3:0]      cap_blank;
  logic [3:0]      seen;
  logic            bad_code_r, bad_an_r;
  logic [15:0]     frame_digits_r;
  logic [3:0]      frame_blank_r;
  logic            frame_load, frame_valid_c;

  // Map an active-low glyph back to {legal, nibble}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    case (s)
      7'h40: glyph_decode = {1'b1, 4'h0};
      7'h79: glyph_decode = {1'b1, 4'h1};
      7'h24: glyph_decode = {1'b1, 4'h2};
      7'h30: glyph_decode = {1'b1, 4'h3};
      7'h19: glyph_decode = {1'b1, 4'h4};
      7'h12: glyph_decode = {1'b1, 4'h5};
      7'h02: glyph_decode = {1'b1, 4'h6};
      7'h78: glyph_decode = {1'b1, 4'h7};
      7'h00: glyph_decode = {1'b1, 4'h8};
      7'h10: glyph_decode = {1'b1, 4'h9};
      7'h08: glyph_decode = {1'b1, 4'hA};
      7'h03: glyph_decode = {1'b1, 4'hB};
      7'h46: glyph_decode = {1'b1, 4'hC};
      7'h21: glyph_decode = {1'b1, 4'hD};
      7'h06: glyph_decode = {1'b1, 4'hE};
      7'h0E: glyph_decode = {1'b1, 4'hF};
      default: glyph_decode = 5'd0;
    endcase
  endfunction

  // Two-flop synchronizer plus settle timer. The timer counts down the clocks
  // still required before a sample; any change reloads it, and the single
  // 1 -> 0 step marks the one sample of each stable period.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      cnt_rem <= STABLE_LD;
    end else begin
      s1 <= {bus.an, bus.seg};
      s2 <= s1;
      if (s1 != s2)
        cnt_rem <= STABLE_LD;
      else if (cnt_rem != 8'd0)
        cnt_rem <= cnt_rem - 8'd1;
    end
  end

  assign sample = (s1 == s2) && (cnt_rem == 8'd1);

  // Classify the sampled anode pattern and decode the sampled glyph.
  always_comb begin
    smp_an      = s2[10:7];
    smp_seg     = s2[6:0];
    an_low      = ~smp_an;
    an_idle     = (an_low == 4'd0);
    an_one      = !an_idle && ((an_low & (an_low - 4'd1)) == 4'd0);
    {glyph_ok, glyph_nib} = glyph_decode(smp_seg);
    glyph_blank = (smp_seg == 7'h7F);
  end

  // Per-digit capture registers, seen mask and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_digit  <= '0;
      cap_blank  <= '0;
      seen       <= '0;
      bad_code_r <= 1'b0;
      bad_an_r   <= 1'b0;
    end else begin
      bad_code_r <= 1'b0;
      bad_an_r   <= 1'b0;
      if (state == PUBLISH)
        seen <= '0;
      if (sample && an_one) begin
        for (int k = 0; k < 4; k++) begin
          if (an_low[k]) begin
            if (glyph_ok) begin
              cap_digit[k] <= glyph_nib;
              cap_blank[k] <= 1'b0;
              seen[k]      <= 1'b1;
            end else if (glyph_blank) begin
              cap_digit[k] <= 4'd0;
              cap_blank[k] <= 1'b1;
              seen[k]      <= 1'b1;
            end else begin
              bad_code_r   <= 1'b1;
              seen[k]      <= 1'b0;
            end
          end
        end
      end
      if (sample && !an_idle && !an_one)
        bad_an_r <= 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  // Frame FSM next state; frame regs load on entry to PUBLISH so they are
  // already current while frame_valid is high.
  always_comb begin
    state_nxt     = state;
    frame_load    = 1'b0;
    frame_valid_c = 1'b0;
    case (state)
      COLLECT: begin
        if (seen == 4'hF) begin
          state_nxt  = PUBLISH;
          frame_load = 1'b1;
        end
      end
      PUBLISH: begin
        frame_valid_c = 1'b1;
        state_nxt     = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Published frame holds until the next complete frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_digits_r <= '0;
      frame_blank_r  <= '0;
    end else if (frame_load) begin
      frame_digits_r <= cap_digit;
      frame_blank_r  <= cap_blank;
    end
  end

  assign bus.frame_digits = frame_digits_r;
  assign bus.frame_blank  = frame_blank_r;
  assign bus.frame_valid  = frame_valid_c;
  assign bus.bad_code     = bad_code_r;
  assign bus.bad_an       = bad_an_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios followed by random pin holds.
// A behavioural model predicts every pulse (kind, cycle, frame contents) into a
// queue; a monitor pops and compares whenever the DUT pulses.
module tb_seg7_scan_capture;
  localparam int STABLE = 4;
  localparam int K_BADC = 0, K_BADAN = 1, K_FRAME = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seg7_scan_capture_if bus();

  seg7_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          kind;
    logic [15:0] digits;
    logic [3:0]  blank;
    int          at;
  } evt_t;

  evt_t exp_q[$];

  // Glyphs described by which segments are lit, independent of any hex table.
  string      lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  logic [6:0] glyph[16];
  logic [3:0] m_digit[4];
  bit         m_blank[4];
  bit         m_seen[4];
  logic [3:0] last_an;
  logic [6:0] last_seg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    evt_t e;
    e.kind   = kind;
    e.at     = at;
    e.digits = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
    e.blank  = {m_blank[3], m_blank[2], m_blank[1], m_blank[0]};
    exp_q.push_back(e);
  endtask

  // Reference behaviour of one settled sample of (an, seg) whose pins began at cycle start.
  task automatic model_sample(input logic [3:0] an, input logic [6:0] seg, input int start);
    int lows = 0;
    int k = 0;
    int nib = -1;
    for (int i = 0; i < 4; i++)
      if (an[i] == 1'b0) begin
        lows++;
        k = i;
      end
    if (lows == 0) return;
    if (lows > 1) begin
      push(K_BADAN, start + STABLE + 2);
      return;
    end
    for (int d = 0; d < 16; d++)
      if (glyph[d] == seg) nib = d;
    if (nib >= 0) begin
      m_digit[k] = 4'(nib);
      m_blank[k] = 1'b0;
      m_seen[k]  = 1'b1;
    end else if (seg == 7'h7F) begin
      m_digit[k] = 4'd0;
      m_blank[k] = 1'b1;
      m_seen[k]  = 1'b1;
    end else begin
      push(K_BADC, start + STABLE + 2);
      m_seen[k] = 1'b0;
      return;
    end
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      push(K_FRAME, start + STABLE + 3);
      for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    end
  endtask

  // Drive pins at a falling edge and keep them for len clocks. Lengths used are
  // either at most STABLE or at least STABLE+2, well clear of the settle boundary.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int len);
    bus.an   = an;
    bus.seg  = seg;
    last_an  = an;
    last_seg = seg;
    if (len >= STABLE + 2) model_sample(an, seg, cyc);
    repeat (len) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an  = an;
    bus.seg = seg;
    rst     = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_frame_digits", 32'(bus.frame_digits), 32'h0);
      chk("rst_frame_blank", 32'(bus.frame_blank), 32'h0);
      chk("rst_pulses", {29'd0, bus.frame_valid, bus.bad_code, bus.bad_an}, 32'h0);
    end
    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    rst = 1'b0;
    hold(4'b1111, 7'h7F, 10);
  endtask

  task automatic take(input int kind);
    evt_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_pulse kind=%0d at cycle %0d: none expected", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.at != cyc ||
        (kind == K_FRAME && (bus.frame_digits !== e.digits || bus.frame_blank !== e.blank))) begin
      miscompares++;
      $display("FAIL pulse: got kind=%0d cyc=%0d digits=%h blank=%b, expected kind=%0d cyc=%0d digits=%h blank=%b",
               kind, cyc, bus.frame_digits, bus.frame_blank, e.kind, e.at, e.digits, e.blank);
    end
  endtask

  // Monitor: every pulse must match the next predicted event.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.bad_code === 1'b1)    take(K_BADC);
      if (bus.bad_an === 1'b1)      take(K_BADAN);
      if (bus.frame_valid === 1'b1) take(K_FRAME);
    end
  end

  initial begin
    logic [6:0] g;
    logic [3:0] an;
    logic [6:0] seg;
    int         r;
    for (int i = 0; i < 16; i++) begin
      g = 7'h7F;
      for (int j = 0; j < lit[i].len(); j++) g[int'(lit[i][j]) - 97] = 1'b0;
      glyph[i] = g;
    end
    for (int i = 0; i < 4; i++) begin
      m_digit[i] = 4'd0;
      m_blank[i] = 1'b0;
      m_seen[i]  = 1'b0;
    end
    bus.an  = 4'b1111;
    bus.seg = 7'h7F;
    @(negedge clk);

    // reset with a live digit on the pins
    do_reset(4'b1110, 7'h79, 3);

    // plain frame 4321
    hold(4'b1110, 7'h79, 10);
    hold(4'b1101, 7'h24, 10);
    hold(4'b1011, 7'h30, 10);
    hold(4'b0111, 7'h19, 10);
    hold(4'b1111, 7'h7F, 10);
    chk("frame_hold_digits", 32'(bus.frame_digits), 32'h4321);
    chk("frame_hold_blank", 32'(bus.frame_blank), 32'h0);

    // short hold is ignored, long hold captures
    hold(4'b1110, 7'h40, STABLE);
    hold(4'b1111, 7'h7F, 10);
    hold(4'b1110, 7'h40, STABLE + 2);
    hold(4'b1111, 7'h7F, 10);

    // illegal glyph, multiple anodes, idle, then a full frame 8765
    hold(4'b1110, 7'h7E, 10);
    hold(4'b1100, 7'h40, 10);
    hold(4'b1111, 7'h7F, 10);
    hold(4'b1110, 7'h12, 10);
    hold(4'b1101, 7'h02, 10);
    hold(4'b1011, 7'h78, 10);
    hold(4'b0111, 7'h00, 10);

    // blank digit and overwrite within a frame
    hold(4'b0111, 7'h7F, 8);
    hold(4'b1110, 7'h79, 8);
    hold(4'b1110, 7'h0E, 8);
    hold(4'b1101, 7'h40, 8);
    hold(4'b1011, 7'h40, 8);
    chk("blank_frame_digits", 32'(bus.frame_digits), 32'h000F);
    chk("blank_frame_blank", 32'(bus.frame_blank), 32'h8);

    // reset discards a partial frame
    hold(4'b1110, 7'h08, 8);
    hold(4'b1101, 7'h03, 8);
    do_reset(4'b1111, 7'h7F, 1);
    hold(4'b1011, 7'h46, 8);
    hold(4'b0111, 7'h21, 8);
    hold(4'b1110, 7'h06, 8);
    hold(4'b1101, 7'h0E, 8);

    // random holds: glitches and settled values of every class
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       an = ~(4'(1) << $urandom_range(0, 3));
      else if (r == 7) an = 4'b1111;
      else             an = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       seg = glyph[$urandom_range(0, 15)];
      else if (r == 7) seg = 7'h7F;
      else             seg = 7'($urandom);
      if (an == last_an && seg == last_seg) seg = seg ^ 7'h01;
      if ($urandom_range(0, 3) == 0) hold(an, seg, $urandom_range(1, STABLE - 1));
      else                           hold(an, seg, $urandom_range(STABLE + 4, STABLE + 10));
    end

    repeat (20) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
